// File: rtl/duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module     : duty_ramp_pkg
// Description: Shared constants for the duty ramp sequencer. Holds the channel
//              count ceiling, the default duty width, the power-on duties of
//              the three PWM channels (these match the duty register bank) and
//              the sequencer FSM encoding.
// Revision   : 1.0 - initial release
// ============================================================================
package duty_ramp_pkg;

    localparam int NCH_MAX   = 3;
    localparam int DUTY_W    = 8;

    localparam int DUTY0_RST = 64;
    localparam int DUTY1_RST = 128;
    localparam int DUTY2_RST = 192;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Power-on duty of channel ch; returned as int so callers with a
    // different duty width can size it themselves.
    function automatic int duty_rst(input int ch);
        case (ch)
            0:       duty_rst = DUTY0_RST;
            1:       duty_rst = DUTY1_RST;
            default: duty_rst = DUTY2_RST;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_tick_gen.sv
`default_nettype none
// ============================================================================
// Module     : ramp_tick_gen
// Description: Ramp tick generator. Counts 0..STEP_DIV-1 while enabled and
//              raises o_tick during the last count. Disabling forces the
//              counter to 0, so a re-enable always waits a full period.
// Ports      : clk    - system clock
//              rst    - synchronous active-high reset
//              i_en   - 1 = count, 0 = hold counter at 0
//              o_tick - high in the cycle the counter is at STEP_DIV-1
// Revision   : 1.0 - initial release
// ============================================================================
module ramp_tick_gen #(
    parameter int STEP_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int               CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/duty_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : duty_ramp_sequencer
// Description: Holds a target duty per PWM channel and, on every ramp tick,
//              walks the channels one per clock, issuing a single-cycle write
//              that moves each channel's duty STEP closer to its target
//              (landing exactly on the target for the final step).
// Ports      : clk     - system clock (shared with the duty register bank)
//              rst     - synchronous active-high reset
//              en      - ramp enable; 0 holds the tick counter at 0
//              tgt_wr  - 1-cycle pulse: load tgt_val into target tgt_ch
//              tgt_ch  - target channel (values >= NCH are ignored)
//              tgt_val - new target duty
//              we      - 1-cycle write strobe to the duty register bank
//              ch_sel  - channel being written (held between writes)
//              duty_in - duty being written (held between writes)
//              busy    - 1 while any channel's duty differs from its target
//              done    - per-channel pulse with the write that hits target
// Macro      : DUTY_RAMP_DONE_EN - when defined, drives done; when undefined,
//              done is tied to 0.
// Revision   : 1.0 - initial release
// ============================================================================
module duty_ramp_sequencer #(
    parameter int NCH      = 3,
    parameter int DUTY_W   = duty_ramp_pkg::DUTY_W,
    parameter int STEP     = 4,
    parameter int STEP_DIV = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               tgt_wr,
    input  logic [1:0]                         tgt_ch,
    input  logic [DUTY_W-1:0]                  tgt_val,
    output logic                               we,
    output logic [1:0]                         ch_sel,
    output logic [DUTY_W-1:0]                  duty_in,
    output logic                               busy,
    output logic [duty_ramp_pkg::NCH_MAX-1:0]  done
);

    import duty_ramp_pkg::*;

    localparam logic [1:0]        C_LAST_CH = 2'(NCH - 1);
    localparam logic [DUTY_W-1:0] C_STEP    = DUTY_W'(STEP);

    logic [0:0]        r_state;
    logic [1:0]        r_idx;
    logic [DUTY_W-1:0] r_cur [NCH];
    logic [DUTY_W-1:0] r_tgt [NCH];
    logic              r_we;
    logic [1:0]        r_ch_sel;
    logic [DUTY_W-1:0] r_duty;
    logic              r_busy;

    logic              w_tick;
    logic [DUTY_W-1:0] w_cur_sel;
    logic [DUTY_W-1:0] w_tgt_sel;
    logic [DUTY_W:0]   w_diff;
    logic [DUTY_W:0]   w_abs;
    logic              w_up;
    logic              w_differs;
    logic [DUTY_W-1:0] w_next;
    logic              w_busy_next;

    ramp_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .o_tick (w_tick)
    );

    // Step of the channel under scan. The difference is one bit wider than
    // the duty so its sign is exact; a remaining gap of at most STEP snaps
    // straight to the target, which is what keeps cur+STEP / cur-STEP from
    // ever wrapping past 0 or full scale.
    always_comb begin
        w_cur_sel = r_cur[r_idx];
        w_tgt_sel = r_tgt[r_idx];
        w_diff    = {1'b0, w_tgt_sel} - {1'b0, w_cur_sel};
        w_up      = ~w_diff[DUTY_W];
        w_abs     = w_up ? w_diff : (~w_diff + 1'b1);
        w_differs = (w_cur_sel != w_tgt_sel);
        if (w_abs <= {1'b0, C_STEP}) begin
            w_next = w_tgt_sel;
        end else if (w_up) begin
            w_next = w_cur_sel + C_STEP;
        end else begin
            w_next = w_cur_sel - C_STEP;
        end
    end

    always_comb begin
        w_busy_next = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (r_cur[i] != r_tgt[i]) begin
                w_busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_ch_sel <= '0;
            r_duty   <= '0;
            r_busy   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_cur[i] <= DUTY_W'(duty_rst(i));
                r_tgt[i] <= DUTY_W'(duty_rst(i));
            end
        end else begin
            r_we   <= 1'b0;
            r_busy <= w_busy_next;

            // A target loaded while its channel is under scan lands at the
            // same edge as the step, so that step still uses the old target.
            if (tgt_wr && (tgt_ch <= C_LAST_CH)) begin
                r_tgt[tgt_ch] <= tgt_val;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_SCAN;
                        r_idx   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_differs) begin
                        r_cur[r_idx] <= w_next;
                        r_we         <= 1'b1;
                        r_ch_sel     <= r_idx;
                        r_duty       <= w_next;
                    end
                    if (r_idx == C_LAST_CH) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign we      = r_we;
    assign ch_sel  = r_ch_sel;
    assign duty_in = r_duty;
    assign busy    = r_busy;

`ifdef DUTY_RAMP_DONE_EN
    logic [NCH_MAX-1:0] r_done;

    // Raised together with the write strobe, and only by a scan step; a
    // target load that happens to equal the current duty never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
        end else begin
            r_done <= '0;
            if ((r_state == ST_SCAN) && w_differs && (w_next == w_tgt_sel)) begin
                r_done <= NCH_MAX'(1) << r_idx;
            end
        end
    end

    assign done = r_done;
`else
    assign done = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_duty_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_duty_ramp_sequencer
// Description: Self-checking bench for duty_ramp_sequencer. A behavioural
//              model predicts every output each cycle; directed scenarios add
//              hand-computed expectations on the logged write stream.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_duty_ramp_sequencer;

    localparam int NCH      = 3;
    localparam int STEP     = 4;
    localparam int STEP_DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tgt_wr = 1'b0;
    logic [1:0] tgt_ch = 2'd0;
    logic [7:0] tgt_val = 8'd0;
    logic       we;
    logic [1:0] ch_sel;
    logic [7:0] duty_in;
    logic       busy;
    logic [2:0] done;

    duty_ramp_sequencer #(
        .NCH      (NCH),
        .DUTY_W   (8),
        .STEP     (STEP),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tgt_wr  (tgt_wr),
        .tgt_ch  (tgt_ch),
        .tgt_val (tgt_val),
        .we      (we),
        .ch_sel  (ch_sel),
        .duty_in (duty_in),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;
    int cyc     = 0;

    int q_cyc[$];
    int q_ch[$];
    int q_val[$];
    int q_done_cyc[$];
    int n_done_nz = 0;

    // Model state: duties/targets as plain integers, a tick counter, and the
    // channel to be stepped next (-1 when no scan is running).
    int   m_cur [NCH];
    int   m_tgt [NCH];
    int   m_cnt  = 0;
    int   m_scan = -1;
    bit   have_exp = 1'b0;
    logic e_we = 1'b0;
    int   e_ch = 0;
    int   e_duty = 0;
    logic e_busy = 1'b0;
    logic [2:0] e_done = 3'b000;

    always @(negedge clk) begin : p_model
        int  ch;
        int  d;
        int  nv;
        bit  any_diff;
        cyc++;
        if (have_exp) begin
            n_tests++;
            if (we !== e_we || ch_sel !== 2'(e_ch) || duty_in !== 8'(e_duty) ||
                busy !== e_busy || done !== e_done) begin
                n_fail++;
                if (n_print < 20) begin
                    $display("FAIL cycle_check cyc=%0d got we=%b ch=%0d duty=%0d busy=%b done=%b, need we=%b ch=%0d duty=%0d busy=%b done=%b",
                             cyc, we, ch_sel, duty_in, busy, done, e_we, e_ch, e_duty, e_busy, e_done);
                end
                n_print++;
            end
        end
        if (we === 1'b1) begin
            q_cyc.push_back(cyc);
            q_ch.push_back(int'(ch_sel));
            q_val.push_back(int'(duty_in));
        end
        if (done !== 3'b000) begin
            n_done_nz++;
            if (done[0] === 1'b1) q_done_cyc.push_back(cyc);
        end

        // Predict the outputs that follow the coming clock edge.
        if (rst) begin
            m_cur[0] = 64;  m_cur[1] = 128; m_cur[2] = 192;
            m_tgt[0] = 64;  m_tgt[1] = 128; m_tgt[2] = 192;
            m_cnt = 0; m_scan = -1;
            e_we = 1'b0; e_ch = 0; e_duty = 0; e_busy = 1'b0; e_done = 3'b000;
        end else begin
            any_diff = 1'b0;
            for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) any_diff = 1'b1;
            e_busy = any_diff;
            e_we   = 1'b0;
            e_done = 3'b000;
            if (m_scan >= 0) begin
                ch = m_scan;
                if (m_cur[ch] != m_tgt[ch]) begin
                    d  = m_tgt[ch] - m_cur[ch];
                    if (d <= STEP && d >= -STEP) nv = m_tgt[ch];
                    else if (d > 0)              nv = m_cur[ch] + STEP;
                    else                         nv = m_cur[ch] - STEP;
                    m_cur[ch] = nv;
                    e_we = 1'b1; e_ch = ch; e_duty = nv;
`ifdef DUTY_RAMP_DONE_EN
                    if (nv == m_tgt[ch]) e_done[ch] = 1'b1;
`endif
                end
                m_scan = (ch == NCH - 1) ? -1 : ch + 1;
            end else if (en && m_cnt == STEP_DIV - 1) begin
                m_scan = 0;
            end
            m_cnt = en ? (m_cnt + 1) % STEP_DIV : 0;
            if (tgt_wr && int'(tgt_ch) < NCH) m_tgt[tgt_ch] = int'(tgt_val);
        end
        have_exp = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d need=%0d", name, got, exp);
        end
    endtask

    task automatic write_tgt(input int ch, input int v);
        tgt_wr  = 1'b1;
        tgt_ch  = 2'(ch);
        tgt_val = 8'(v);
        step(1);
        tgt_wr  = 1'b0;
    endtask

    function automatic int count_ch(input int from, input int ch);
        int n = 0;
        for (int i = from; i < q_ch.size(); i++) if (q_ch[i] == ch) n++;
        return n;
    endfunction

    // n-th (0-based) write to channel ch at or after log index from; returns
    // its value (sel=0) or cycle (sel=1), or -1 when absent.
    function automatic int nth(input int from, input int ch, input int n, input bit sel);
        int k = 0;
        for (int i = from; i < q_ch.size(); i++) begin
            if (q_ch[i] == ch) begin
                if (k == n) return sel ? q_cyc[i] : q_val[i];
                k++;
            end
        end
        return -1;
    endfunction

    initial begin : p_stim
        int  base;
        int  mark;
        int  c0;
        int  last;
        int  bad;
        bit  found;

        // 1. Reset
        step(2);
        rst = 1'b0;
        check("rst_we", 32'(we), 0);
        check("rst_ch_sel", 32'(ch_sel), 0);
        check("rst_duty_in", 32'(duty_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        step(100);
        check("rst_no_writes", q_ch.size(), 0);

        // 2. Up ramp 64 -> 80
        base = q_ch.size();
        en = 1'b1;
        write_tgt(0, 80);
        step(100);
        check("up_count", count_ch(base, 0), 4);
        check("up_w0", nth(base, 0, 0, 0), 68);
        check("up_w1", nth(base, 0, 1, 0), 72);
        check("up_w2", nth(base, 0, 2, 0), 76);
        check("up_w3", nth(base, 0, 3, 0), 80);
        check("up_gap01", nth(base, 0, 1, 1) - nth(base, 0, 0, 1), 16);
        check("up_gap12", nth(base, 0, 2, 1) - nth(base, 0, 1, 1), 16);
        check("up_gap23", nth(base, 0, 3, 1) - nth(base, 0, 2, 1), 16);
        check("up_busy_low", 32'(busy), 0);
`ifdef DUTY_RAMP_DONE_EN
        check("done_pulses", q_done_cyc.size(), 1);
        if (q_done_cyc.size() > 0) check("done_align", q_done_cyc[0], nth(base, 0, 3, 1));
`endif

        // 3A. 128 -> 126 in one saturating step
        base = q_ch.size();
        write_tgt(1, 126);
        step(40);
        check("sat_down_count", count_ch(base, 1), 1);
        check("sat_down_val", nth(base, 1, 0, 0), 126);

        // 3B. 192 -> 255 without wrapping
        base = q_ch.size();
        write_tgt(2, 255);
        step(16 * 17 + 20);
        check("sat_up_count", count_ch(base, 2), 16);
        check("sat_up_prev", nth(base, 2, 14, 0), 252);
        check("sat_up_last", nth(base, 2, 15, 0), 255);
        bad = 0;
        for (int i = base; i < q_ch.size(); i++)
            if (q_ch[i] == 2 && (q_val[i] == 0 || q_val[i] == 3)) bad++;
        check("sat_up_nowrap", bad, 0);

        // 4A. Out-of-range channel is ignored
        base = q_ch.size();
        write_tgt(3, 0);
        step(50);
        check("bad_ch_writes", q_ch.size() - base, 0);
        check("bad_ch_busy", 32'(busy), 0);

        // 4B. en=0 mid-ramp freezes writes; resume after a full tick period
        write_tgt(0, 200);
        step(50);
        en = 1'b0;
        step(5);
        mark = q_ch.size();
        step(60);
        check("hold_no_writes", q_ch.size() - mark, 0);
        last = (mark > 0) ? q_val[mark - 1] : -1;
        base = q_ch.size();
        c0 = cyc;
        en = 1'b1;
        step(30);
        check("resume_ch", nth(base, 0, 0, 1) >= 0 ? 0 : 1, 0);
        check("resume_delay", nth(base, 0, 0, 1) - c0, 18);
        check("resume_val", nth(base, 0, 0, 0), last + 4);

        // 4C. Target change during ch0's own scan step uses the old target
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (m_scan == 0) found = 1'b1;
        end
        check("race_found_scan", 32'(found), 1);
        last = -1;
        for (int i = 0; i < q_ch.size(); i++) if (q_ch[i] == 0) last = q_val[i];
        base = q_ch.size();
        write_tgt(0, last);
        step(40);
        check("race_count", count_ch(base, 0), 2);
        check("race_old_tgt", nth(base, 0, 0, 0), last + 4);
        check("race_new_tgt", nth(base, 0, 1, 0), last);

        // 5. Reset mid-ramp
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        write_tgt(0, 200);
        step(50);
        rst = 1'b1;
        step(1);
        check("midrst_we", 32'(we), 0);
        check("midrst_duty", 32'(duty_in), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        base = q_ch.size();
        step(100);
        check("midrst_no_writes", q_ch.size() - base, 0);
        base = q_ch.size();
        write_tgt(0, 68);
        write_tgt(1, 132);
        write_tgt(2, 188);
        step(40);
        check("midrst_cur0", nth(base, 0, 0, 0), 68);
        check("midrst_cur1", nth(base, 1, 0, 0), 132);
        check("midrst_cur2", nth(base, 2, 0, 0), 188);
        check("midrst_total", q_ch.size() - base, 3);

`ifndef DUTY_RAMP_DONE_EN
        check("done_tied_low", n_done_nz, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
